// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between NUM_REQ requesters.
//
// A round-robin arbiter accepts one operation at a time. The controller holds
// the ALU operands stable for one cycle (simple ops) or MULDIV_LAT cycles
// (mul/div), registers the ALU result and status, and holds the response until
// it is accepted.
//
// Build option:
//   ALU_SHARE_DIVZERO_TRAP_EN - when defined, a div with op2 == 0 skips EXEC and
//   answers at once with result 32'hFFFF_FFFF and status 8'h04.
//
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   req_valid_i/req_ready_o   per-requester handshake (ready is a one-hot grant)
//   req_ctrl_i, req_op1_i/2_i packed per-requester ctrl (4b) and operands (32b)
//   alu_ctrl_o, alu_op1_o/2_o drive to the ALU (NOP/0 outside EXEC)
//   alu_result_i, alu_status_i ALU outputs
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_id_o, rsp_result_o, rsp_status_o  registered response
//   busy_o                    FSM is not idle
module alu_share_ctrl #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [4*NUM_REQ-1:0]       req_ctrl_i,
    input  logic [32*NUM_REQ-1:0]      req_op1_i,
    input  logic [32*NUM_REQ-1:0]      req_op2_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [3:0]                 alu_ctrl_o,
    output logic [31:0]                alu_op1_o,
    output logic [31:0]                alu_op2_o,
    input  logic [31:0]                alu_result_i,
    input  logic [7:0]                 alu_status_i,
    output logic                       rsp_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    output logic [31:0]                rsp_result_o,
    output logic [7:0]                 rsp_status_o,
    input  logic                       rsp_ready_i,
    output logic                       busy_o
);

    localparam int unsigned IdW   = $clog2(NUM_REQ);
    localparam int unsigned CandW = IdW + 1;
    localparam int unsigned CntW  = $clog2(MULDIV_LAT + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [3:0] CtrlNop = 4'b1111;
    localparam logic [3:0] CtrlMul = 4'b1000;
    localparam logic [3:0] CtrlDiv = 4'b1001;

    localparam logic [CntW-1:0]  CntMulDiv = CntW'(MULDIV_LAT - 1);
    localparam logic [CandW-1:0] NumReqW   = CandW'(NUM_REQ);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdW-1:0]  last_q, last_d;
    logic [IdW-1:0]  id_q, id_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [31:0]     op1_q, op1_d;
    logic [31:0]     op2_q, op2_d;
    logic [31:0]     result_q, result_d;
    logic [7:0]      status_q, status_d;

    logic             grant_found;
    logic [IdW-1:0]   grant_idx;
    logic [CandW-1:0] cand;
    logic [3:0]       sel_ctrl;
    logic [31:0]      sel_op1;
    logic [31:0]      sel_op2;
    logic             is_trap;

    // Round-robin search starting just after the last grant, with wrap-around.
    // cand never exceeds 2*NUM_REQ-1, so one conditional subtraction wraps it.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_q;
        cand        = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + CandW'(k);
            if (cand >= NumReqW) begin
                cand = cand - NumReqW;
            end
            if (!grant_found && req_valid_i[cand[IdW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IdW-1:0];
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_ctrl = '0;
        sel_op1  = '0;
        sel_op2  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IdW'(i)) begin
                sel_ctrl = req_ctrl_i[4*i +: 4];
                sel_op1  = req_op1_i[32*i +: 32];
                sel_op2  = req_op2_i[32*i +: 32];
            end
        end
    end

`ifdef ALU_SHARE_DIVZERO_TRAP_EN
    assign is_trap = (sel_ctrl == CtrlDiv) && (sel_op2 == '0);
`else
    assign is_trap = 1'b0;
`endif

    // Grant is held off during reset so no transfer is signalled at a reset edge.
    always_comb begin
        req_ready_o = '0;
        if (rst_ni && (state_q == StIdle) && grant_found) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        id_d     = id_q;
        ctrl_d   = ctrl_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        status_d = status_q;
        case (state_q)
            StIdle: begin
                if (grant_found) begin
                    last_d = grant_idx;
                    id_d   = grant_idx;
                    if (is_trap) begin
                        // ALU drive stays at NOP; the answer is synthesised here.
                        state_d  = StResp;
                        result_d = 32'hFFFF_FFFF;
                        status_d = 8'b0000_0100;
                    end else begin
                        state_d = StExec;
                        ctrl_d  = sel_ctrl;
                        op1_d   = sel_op1;
                        op2_d   = sel_op2;
                        cnt_d   = ((sel_ctrl == CtrlMul) || (sel_ctrl == CtrlDiv)) ?
                                  CntMulDiv : '0;
                    end
                end
            end
            StExec: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d  = StResp;
                    result_d = alu_result_i;
                    status_d = alu_status_i;
                    // Return the ALU to NOP so every issue is a ctrl transition.
                    ctrl_d   = CtrlNop;
                    op1_d    = '0;
                    op2_d    = '0;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            last_q   <= IdW'(NUM_REQ - 1);
            id_q     <= '0;
            ctrl_q   <= CtrlNop;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            id_q     <= id_d;
            ctrl_q   <= ctrl_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign alu_ctrl_o   = ctrl_q;
    assign alu_op1_o    = op1_q;
    assign alu_op2_o    = op2_q;
    assign rsp_valid_o  = (state_q == StResp);
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign rsp_status_o = status_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_ctrl.sv
`timescale 1ns/1ps
module tb_alu_share_ctrl;

    localparam int unsigned N   = 4;
    localparam int unsigned L   = 4;
    localparam int unsigned IdW = $clog2(N);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [4*N-1:0]      req_ctrl;
    logic [32*N-1:0]     req_op1;
    logic [32*N-1:0]     req_op2;
    logic [N-1:0]        req_ready;
    logic [3:0]          alu_ctrl;
    logic [31:0]         alu_op1;
    logic [31:0]         alu_op2;
    logic [31:0]         alu_result;
    logic [7:0]          alu_status;
    logic                rsp_valid;
    logic [IdW-1:0]      rsp_id;
    logic [31:0]         rsp_result;
    logic [7:0]          rsp_status;
    logic                rsp_ready = 1'b1;
    logic                busy;

    logic [3:0]  rc[N];
    logic [31:0] ra[N];
    logic [31:0] rb[N];

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    logic rst_at_edge = 1'b0;

    typedef struct {
        int unsigned id;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [7:0]  s;
        int unsigned acc;
        int unsigned rise;
    } exp_t;

    exp_t q[$];
    exp_t glog[$];
    int   m_last = N - 1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst_n;
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_ctrl[4*i +: 4]  = rc[i];
            req_op1[32*i +: 32] = ra[i];
            req_op2[32*i +: 32] = rb[i];
        end
    end

    // Reference ALU: used both as the stand-in ALU and to predict results.
    function automatic void alu_model(input logic [3:0] c, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output logic [7:0] s);
        logic [32:0] w;
        logic cy, ov, dz;
        w = '0; cy = 1'b0; ov = 1'b0; dz = 1'b0; r = '0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cy = w[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0011: r = a ^ b;
            4'b0110: begin
                w = {1'b0, a} - {1'b0, b}; r = w[31:0]; cy = w[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b1000: r = a * b;
            4'b1001: if (b == 0) begin r = '0; dz = 1'b1; end else r = a / b;
            default: r = '0;
        endcase
        s = {(r == 0), ov, cy, r[31], r[0], dz, 2'b00};
    endfunction

    always_comb alu_model(alu_ctrl, alu_op1, alu_op2, alu_result, alu_status);

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    alu_share_ctrl #(.NUM_REQ(N), .MULDIV_LAT(L)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ctrl_i   (req_ctrl),
        .req_op1_i    (req_op1),
        .req_op2_i    (req_op2),
        .req_ready_o  (req_ready),
        .alu_ctrl_o   (alu_ctrl),
        .alu_op1_o    (alu_op1),
        .alu_op2_o    (alu_op2),
        .alu_result_i (alu_result),
        .alu_status_i (alu_status),
        .rsp_valid_o  (rsp_valid),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .rsp_status_o (rsp_status),
        .rsp_ready_i  (rsp_ready),
        .busy_o       (busy)
    );

    // Stimulus side: on an observed handshake, push the expected response.
    task automatic observe();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id = i; e.c = rc[i]; e.a = ra[i]; e.b = rb[i];
                e.acc = cyc + 1;
                alu_model(e.c, e.a, e.b, e.r, e.s);
                e.rise = e.acc + (((e.c == 4'b1000) || (e.c == 4'b1001)) ? L : 1);
`ifdef ALU_SHARE_DIVZERO_TRAP_EN
                if (e.c == 4'b1001 && e.b == 0) begin
                    e.r = 32'hFFFF_FFFF; e.s = 8'h04; e.rise = e.acc;
                end
`endif
                q.push_back(e);
                glog.push_back(e);
            end
        end
    endtask

    task automatic tick();
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req(input int i);
        logic [3:0] tbl[9];
        tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b1000, 4'b1001,
                4'b0101, 4'b1100};
        rc[i] = tbl[$urandom_range(0, 8)];
        ra[i] = $urandom();
        case ($urandom_range(0, 3))
            0: rb[i] = '0;
            1: rb[i] = $urandom_range(1, 20);
            default: rb[i] = $urandom();
        endcase
    endtask

    task automatic issue(input int id, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
        int n0;
        int k;
        n0 = glog.size();
        k = 0;
        req_valid = '0;
        req_valid[id] = 1'b1;
        rc[id] = c; ra[id] = a; rb[id] = b;
        while (glog.size() == n0 && k < 30) begin
            tick();
            k++;
        end
        if (glog.size() == n0) check("issue_timeout", 64'd1, 64'd0);
        req_valid = '0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (q.size() != 0 && k < 60) begin
            tick();
            k++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", 64'd1, 64'd0);
            q.delete();
        end
    endtask

    // Monitor: compares DUT outputs each cycle against the in-flight expectation.
    initial begin : monitor
        exp_t e;
        logic [N-1:0] exp_g;
        int pick;
        bit idle_now, has, in_exec, exp_valid;
        forever begin
            @(negedge clk);
            #2;
            if (cyc >= 1) begin
                if (!rst_at_edge) begin
                    check("rst_busy", busy, 0);
                    check("rst_rsp_valid", rsp_valid, 0);
                    check("rst_alu_ctrl", alu_ctrl, 4'b1111);
                    check("rst_alu_op1", alu_op1, 0);
                    check("rst_alu_op2", alu_op2, 0);
                    check("rst_rsp_id", rsp_id, 0);
                    check("rst_rsp_result", rsp_result, 0);
                    check("rst_rsp_status", rsp_status, 0);
                    while (q.size() > 0 && q[0].acc <= cyc) q.delete(0);
                    m_last = N - 1;
                end
                idle_now = (q.size() == 0) || (q[0].acc == cyc + 1);
                exp_g = '0;
                pick = rr_pick(m_last, req_valid);
                if (rst_n && idle_now && pick >= 0) exp_g[pick] = 1'b1;
                check("req_ready", req_ready, exp_g);
                if (exp_g != '0 && req_ready == exp_g) m_last = pick;
                if (rst_at_edge) begin
                    has = (q.size() > 0) && (q[0].acc <= cyc);
                    if (has) e = q[0];
                    in_exec   = has && (cyc < e.rise);
                    exp_valid = has && (cyc >= e.rise);
                    check("busy", busy, has);
                    check("alu_ctrl", alu_ctrl, in_exec ? e.c : 4'b1111);
                    check("alu_op1", alu_op1, in_exec ? e.a : 32'd0);
                    check("alu_op2", alu_op2, in_exec ? e.b : 32'd0);
                    check("rsp_valid", rsp_valid, exp_valid);
                    if (rsp_valid && exp_valid) begin
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_result", rsp_result, e.r);
                        check("rsp_status", rsp_status, e.s);
                        if (rsp_ready) q.delete(0);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int n0;
        int k;
        for (int i = 0; i < N; i++) begin
            rc[i] = 4'b0010; ra[i] = '0; rb[i] = '0;
        end
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;

        // Round-robin with all requesters asserting.
        n0 = glog.size();
        for (int i = 0; i < N; i++) rand_req(i);
        for (int i = 0; i < N; i++) rc[i] = 4'b0010;
        req_valid = '1;
        repeat (16) tick();
        req_valid = '0;
        wait_done();
        if (glog.size() >= n0 + 5) begin
            for (int j = 0; j < 5; j++) begin
                check("rr_order", glog[n0 + j].id, j % N);
                if (j > 0) check("rr_spacing", glog[n0 + j].acc - glog[n0 + j - 1].acc, 3);
            end
        end else begin
            check("rr_count", glog.size() - n0, 5);
        end

        // Simple add and mul.
        issue(0, 4'b0010, 32'd5, 32'd7);
        wait_done();
        check("add_result", glog[glog.size() - 1].r, 12);
        issue(2, 4'b1000, 32'd6, 32'd7);
        wait_done();
        check("mul_result", glog[glog.size() - 1].r, 42);

        // Backpressure with others waiting.
        rsp_ready = 1'b0;
        issue(1, 4'b0110, $urandom(), $urandom());
        for (int i = 0; i < N; i++) rand_req(i);
        req_valid = '1;
        repeat (8) tick();
        rsp_ready = 1'b1;
        repeat (3) tick();
        req_valid = '0;
        wait_done();

        // Div by zero.
        issue(3, 4'b1001, 32'd100, 32'd0);
        wait_done();

        // Reset in the middle of a mul; requester 0 must win first afterwards.
        issue(2, 4'b1000, 32'd123, 32'd456);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n0 = glog.size();
        req_valid = '1;
        k = 0;
        while (glog.size() == n0 && k < 10) begin
            tick();
            k++;
        end
        req_valid = '0;
        if (glog.size() > n0) check("post_rst_grant", glog[n0].id, 0);
        else check("post_rst_timeout", 64'd1, 64'd0);
        wait_done();

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) rand_req(i);
            req_valid = N'($urandom());
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing controller that shares the single combinational ALU between `NUM_REQ` requesters, for example the fetch/branch unit and the execute stage. A round-robin arbiter accepts one operation at a time. The controller drives the ALU with stable operands for a fixed number of cycles, which is longer for mul/div, and registers the result and status word. It then holds the response until the requester accepts it. It sits between the requesters and the ALU's `ALU_ctrl`/operand inputs and `ALU_result`/`ALU_status` outputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MULDIV_LAT`, 4: EXEC cycles for ctrl `4'b1000` (mul) and `4'b1001` (div), at least 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  NUM_REQ  per-requester operation request.
- `req_ctrl`  in  4*NUM_REQ  ALU control code; requester i uses bits [4i+3:4i].
- `req_op1`, `req_op2`  in  32*NUM_REQ  operands; requester i uses bits [32i+31:32i].
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `alu_ctrl`  out  4  to the ALU control input.
- `alu_op1`, `alu_op2`  out  32  to the ALU operand inputs.
- `alu_result`  in  32  from the ALU.
- `alu_status`  in  8  from the ALU: [7] zero, [6] overflow, [5] carry, [4] negative, [3] odd, [2] div-by-zero.
- `rsp_valid`  out  1  a response is pending.
- `rsp_id`  out  $clog2(NUM_REQ)  index of the owning requester.
- `rsp_result`  out  32  registered ALU result.
- `rsp_status`  out  8  registered ALU status.
- `rsp_ready`  in  1  response accept.
- `busy`  out  1  high when the FSM is not in IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE:**
  - The grant goes to the first `req_valid` bit found by searching from `last_grant+1` upward, with wrap-around.
  - `req_ready` is combinational and asserted only in IDLE, only for the granted index.
  - On transfer the controller latches ctrl, op1, op2 and id, updates `last_grant`, loads `cnt`, and moves to EXEC.
  - With no valid request the FSM stays in IDLE.
- **Counter load:** `cnt` is loaded with `MULDIV_LAT-1` for ctrl 1000/1001 and with 0 for any other code. `cnt` width is `$clog2(MULDIV_LAT+1)`.
- **EXEC:**
  - `alu_*` outputs are driven from the latched registers.
  - While `cnt != 0`, `cnt` decrements each cycle.
  - When `cnt == 0`, the controller captures `alu_result`/`alu_status` into `rsp_result`/`rsp_status` and moves to RESP.
- **RESP:** `rsp_valid` is 1. On `rsp_ready` the FSM moves to IDLE. Without `rsp_ready`, all rsp outputs stay unchanged.
- **ALU drive outside EXEC:** in IDLE and RESP, `alu_ctrl` is the NOP code `4'b1111` and `alu_op1`/`alu_op2` are 0. Every issue therefore produces a ctrl transition at the ALU.
- **Requests:** a requester may drop `req_valid` before it is granted. A request with no grant carries no commitment.
- **Unknown codes:** ctrl codes outside the ALU's set are passed through with single-cycle latency. The ALU returns 0 for them.
- **Reset values:** when `rst_n` is low at an edge, including mid-EXEC or in RESP:
  - state goes to IDLE and any in-flight operation is dropped;
  - `req_ready` = 0 during reset, `rsp_valid` = 0, `rsp_id` = 0;
  - `rsp_result` = 0, `rsp_status` = 0, `busy` = 0;
  - `alu_ctrl` = `4'b1111`, `alu_op1` = `alu_op2` = 0;
  - `cnt` = 0;
  - `last_grant` = `NUM_REQ-1`, so requester 0 wins first after reset.

## Timing
- Accept edge at cycle 0. The EXEC window is 1 cycle for simple ops and `MULDIV_LAT` cycles for mul/div.
- `rsp_valid` rises at cycle 2 for simple ops and at cycle `1+MULDIV_LAT` for mul/div.
- If `rsp_ready` is already high, the response completes in that same cycle. The earliest next accept is one cycle later, in IDLE.
- Peak throughput is one simple op per 3 cycles.
- Operands reach the ALU registered, one cycle after accept. The ALU is combinational, and its output is sampled at the final EXEC edge.

## Configuration
- `ALU_SHARE_DIVZERO_TRAP_EN` defined:
  - On accepting ctrl `4'b1001` with op2 == 0, the FSM goes directly to RESP with `rsp_result=32'hFFFF_FFFF` and `rsp_status=8'b0000_0100`.
  - EXEC is skipped and `alu_ctrl` stays NOP.
  - `rsp_valid` rises at cycle 1.
- Macro not defined: div-by-zero is issued like any div, with full `MULDIV_LAT` latency, and the ALU's outputs are returned unmodified.

## Test plan
- **Reset mid-op:** assert `rst_n` low during EXEC of a mul → next cycle `busy=0`, `rsp_valid=0`, `alu_ctrl=4'b1111`, and requester 0 is granted first afterward.
- **Simple add:** requester 0 sends ctrl `4'b0010`, op1=5, op2=7, `rsp_ready=1` → `rsp_valid` at cycle 2, `rsp_result=12`, `rsp_id=0`, `rsp_status[7]=0`.
- **Mul latency:** requester 2 sends ctrl `4'b1000` with 6×7 and `MULDIV_LAT=4` → `rsp_valid` at cycle 5, `rsp_result=42`, `alu_op1` stable at 6 for 4 cycles.
- **Round-robin:** all four `req_valid` held high and `rsp_ready=1` → grant order 0,1,2,3,0, each grant 3 cycles apart, and `req_ready` is always one-hot.
- **Backpressure:** `rsp_ready=0` for 5 cycles after a response → `rsp_valid`, `rsp_result` and `rsp_id` are stable, `req_ready` stays 0, and the next grant comes one cycle after `rsp_ready` rises.
- **Div-by-zero:** ctrl `4'b1001`, op2=0. With `ALU_SHARE_DIVZERO_TRAP_EN` → `rsp_valid` at cycle 1, result `32'hFFFF_FFFF`, status `8'h04`. Without the macro → response at cycle `1+MULDIV_LAT` carrying the ALU's outputs.
